// File: rtl/exc_controller.sv
// exc_controller: multicycle exception sequencer for the MIPS datapath.
//
// On an invalid-opcode or overflow pulse it stalls the control unit and saves
// EPC = PC-4. It then owns the memory address path for MEM_LATENCY cycles and
// loads PC with a zero-extended handler byte. An eret pulse reloads PC from EPC.
//
// Ports:
//   clock, reset_l           - clock (rising edge), async active-low reset
//   exc_opcode, exc_overflow - single-cycle exception pulses from control/ALU
//   eret                     - single-cycle return-from-exception pulse
//   pc_in, mem_data_in       - current PC, memory read data
//   stall                    - high whenever the sequencer is not idle
//   mem_sel, mem_addr        - memory address override and vector word address
//   pc_load, pc_value        - one-cycle PC write strobe and value
//   epc, cause               - saved PC and last taken exception (01 opc, 10 ovf)
//   double_fault             - sticky, exception arrived while busy
//   exc_count                - only with EXC_COUNT_EN: saturating exception count
//
// Optional feature: define EXC_COUNT_EN to add the exc_count output.
module exc_controller #(
    parameter int unsigned MEM_LATENCY = 2,
    parameter int unsigned VEC_OPCODE  = 254,
    parameter int unsigned VEC_OVF     = 255
) (
    input  logic        clock,
    input  logic        reset_l,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        eret,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_data_in,
    output logic        stall,
    output logic        mem_sel,
    output logic [31:0] mem_addr,
    output logic        pc_load,
    output logic [31:0] pc_value,
    output logic [31:0] epc,
    output logic [1:0]  cause,
    output logic        double_fault
`ifdef EXC_COUNT_EN
    ,
    output logic [15:0] exc_count
`endif
);

    localparam logic [31:0] VecOpc  = 32'(VEC_OPCODE);
    localparam logic [31:0] VecOvf  = 32'(VEC_OVF);
    localparam logic [2:0]  CntInit = 3'(MEM_LATENCY - 1);

    typedef enum logic [2:0] {StIdle, StSave, StWait, StLoad, StRet} state_e;

    state_e      state_q, state_d;
    logic [31:0] vec_q, vec_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] pc_value_q, pc_value_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [2:0]  counter_q, counter_d;
    logic        double_fault_q, double_fault_d;
    logic        take_exc;
    logic [7:0]  load_byte;

    // Little-endian byte lane selected by the low bits of the vector address.
    always_comb begin
        case (vec_q[1:0])
            2'd0:    load_byte = mem_data_in[7:0];
            2'd1:    load_byte = mem_data_in[15:8];
            2'd2:    load_byte = mem_data_in[23:16];
            default: load_byte = mem_data_in[31:24];
        endcase
    end

    always_comb begin
        state_d        = state_q;
        vec_d          = vec_q;
        cause_d        = cause_q;
        epc_d          = epc_q;
        pc_value_d     = pc_value_q;
        mem_addr_d     = mem_addr_q;
        counter_d      = counter_q;
        double_fault_d = double_fault_q;
        take_exc       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (exc_opcode) begin
                    cause_d    = 2'b01;
                    vec_d      = VecOpc;
                    mem_addr_d = VecOpc & ~32'd3;
                    state_d    = StSave;
                    take_exc   = 1'b1;
                end else if (exc_overflow) begin
                    cause_d    = 2'b10;
                    vec_d      = VecOvf;
                    mem_addr_d = VecOvf & ~32'd3;
                    state_d    = StSave;
                    take_exc   = 1'b1;
                end else if (eret) begin
                    pc_value_d = epc_q;
                    state_d    = StRet;
                end
            end
            StSave: begin
                epc_d     = pc_in - 32'd4;
                counter_d = CntInit;
                state_d   = StWait;
            end
            StWait: begin
                if (counter_q == 3'd0) begin
                    state_d = StLoad;
                end else begin
                    counter_d = counter_q - 3'd1;
                end
            end
            StLoad: begin
                // Keep the loaded value visible on pc_value after LOAD.
                pc_value_d = {24'h0, load_byte};
                state_d    = StIdle;
            end
            StRet: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (state_q != StIdle && (exc_opcode || exc_overflow)) begin
            double_fault_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            state_q        <= StIdle;
            vec_q          <= 32'h0;
            cause_q        <= 2'b00;
            epc_q          <= 32'h0;
            pc_value_q     <= 32'h0;
            mem_addr_q     <= 32'h0;
            counter_q      <= 3'd0;
            double_fault_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            vec_q          <= vec_d;
            cause_q        <= cause_d;
            epc_q          <= epc_d;
            pc_value_q     <= pc_value_d;
            mem_addr_q     <= mem_addr_d;
            counter_q      <= counter_d;
            double_fault_q <= double_fault_d;
        end
    end

`ifdef EXC_COUNT_EN
    logic [15:0] exc_count_q;

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            exc_count_q <= 16'h0;
        end else if (take_exc && exc_count_q != 16'hFFFF) begin
            exc_count_q <= exc_count_q + 16'd1;
        end
    end

    assign exc_count = exc_count_q;
`endif

    assign stall        = (state_q != StIdle);
    assign mem_sel      = (state_q == StSave) || (state_q == StWait) || (state_q == StLoad);
    assign pc_load      = (state_q == StLoad) || (state_q == StRet);
    // Only LOAD forwards memory data combinationally; everywhere else registered.
    assign pc_value     = (state_q == StLoad) ? {24'h0, load_byte} : pc_value_q;
    assign mem_addr     = mem_addr_q;
    assign epc          = epc_q;
    assign cause        = cause_q;
    assign double_fault = double_fault_q;

endmodule

// File: tb/tb_exc_controller.sv
module tb_exc_controller;

    localparam int unsigned LAT = 2;

    logic        clock;
    logic        reset_l;
    logic        exc_opcode;
    logic        exc_overflow;
    logic        eret;
    logic [31:0] pc_in;
    logic [31:0] mem_data_in;
    logic        stall;
    logic        mem_sel;
    logic [31:0] mem_addr;
    logic        pc_load;
    logic [31:0] pc_value;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic        double_fault;
`ifdef EXC_COUNT_EN
    logic [15:0] exc_count;
`endif

    exc_controller #(
        .MEM_LATENCY(LAT),
        .VEC_OPCODE (254),
        .VEC_OVF    (255)
    ) dut (
        .clock       (clock),
        .reset_l     (reset_l),
        .exc_opcode  (exc_opcode),
        .exc_overflow(exc_overflow),
        .eret        (eret),
        .pc_in       (pc_in),
        .mem_data_in (mem_data_in),
        .stall       (stall),
        .mem_sel     (mem_sel),
        .mem_addr    (mem_addr),
        .pc_load     (pc_load),
        .pc_value    (pc_value),
        .epc         (epc),
        .cause       (cause),
        .double_fault(double_fault)
`ifdef EXC_COUNT_EN
        ,
        .exc_count   (exc_count)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // kind bits: [0] exc_opcode, [1] exc_overflow, [2] eret
    typedef struct {
        logic [2:0]  kind;
        logic [31:0] pc;
        logic [31:0] data;
        logic        dbl;
        logic [31:0] exp_epc;
        logic [1:0]  exp_cause;
        logic [31:0] exp_pcv;
    } vec_t;

    vec_t        tbl[6];
    logic [31:0] sb_q[$];
    int          checks;
    int          failures;
    logic        df_exp;
    int          taken;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_exc(input vec_t v);
        int          nstall;
        int          load_idx;
        logic [31:0] exp_pcv;
        @(negedge clock);
        exc_opcode   = v.kind[0];
        exc_overflow = v.kind[1];
        eret         = v.kind[2];
        pc_in        = v.pc;
        mem_data_in  = v.data;
        sb_q.push_back(v.exp_pcv);
        @(negedge clock);
        exc_opcode   = 1'b0;
        exc_overflow = 1'b0;
        eret         = 1'b0;
        nstall       = 0;
        load_idx     = -1;
        for (int c = 0; c < 16; c++) begin
            if (!stall) break;
            nstall++;
            chk("mem_sel_busy", 32'(mem_sel), 32'(1));
            chk("mem_addr", mem_addr, 32'h0000_00FC);
            if (pc_load) begin
                load_idx = c;
                if (sb_q.size() == 0) begin
                    chk("sb_nonempty", 32'(0), 32'(1));
                end else begin
                    exp_pcv = sb_q.pop_front();
                    chk("pc_value_load", pc_value, exp_pcv);
                end
            end
            if (v.dbl && c == 1) exc_overflow = 1'b1;
            else exc_overflow = 1'b0;
            @(negedge clock);
        end
        exc_overflow = 1'b0;
        chk("stall_cycles", 32'(nstall), 32'(2 + LAT));
        chk("pc_load_last", 32'(load_idx), 32'(1 + LAT));
        chk("pc_load_idle", 32'(pc_load), 32'(0));
        chk("epc", epc, v.exp_epc);
        chk("cause", 32'(cause), 32'(v.exp_cause));
        if (v.dbl) df_exp = 1'b1;
        chk("double_fault", 32'(double_fault), 32'(df_exp));
        taken++;
    endtask

    task automatic run_eret(input logic [31:0] exp_epc);
        @(negedge clock);
        eret = 1'b1;
        sb_q.push_back(exp_epc);
        @(negedge clock);
        eret = 1'b0;
        chk("eret_stall", 32'(stall), 32'(1));
        chk("eret_pc_load", 32'(pc_load), 32'(1));
        chk("eret_mem_sel", 32'(mem_sel), 32'(0));
        chk("eret_pc_value", pc_value, sb_q.pop_front());
        @(negedge clock);
        chk("eret_stall_end", 32'(stall), 32'(0));
        chk("eret_load_end", 32'(pc_load), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks       = 0;
        failures     = 0;
        df_exp       = 1'b0;
        taken        = 0;
        reset_l      = 1'b0;
        exc_opcode   = 1'b0;
        exc_overflow = 1'b0;
        eret         = 1'b0;
        pc_in        = 32'h0;
        mem_data_in  = 32'h0;

        tbl[0] = '{3'b001, 32'h0000_0020, 32'h0012_3400, 1'b0, 32'h0000_001C, 2'b01, 32'h12};
        tbl[1] = '{3'b010, 32'h0000_0100, 32'hA500_0000, 1'b0, 32'h0000_00FC, 2'b10, 32'hA5};
        tbl[2] = '{3'b001, 32'h0000_0000, 32'h0077_0000, 1'b0, 32'hFFFF_FFFC, 2'b01, 32'h77};
        tbl[3] = '{3'b010, 32'h0000_1234, 32'h3C00_0000, 1'b0, 32'h0000_1230, 2'b10, 32'h3C};
        tbl[4] = '{3'b111, 32'h0000_0080, 32'h00AB_0000, 1'b0, 32'h0000_007C, 2'b01, 32'hAB};
        tbl[5] = '{3'b001, 32'h0000_0040, 32'h0011_0000, 1'b1, 32'h0000_003C, 2'b01, 32'h11};

        repeat (2) @(negedge clock);
        chk("rst_stall", 32'(stall), 32'(0));
        chk("rst_pc_load", 32'(pc_load), 32'(0));
        chk("rst_epc", epc, 32'h0);
        chk("rst_cause", 32'(cause), 32'(0));
        chk("rst_pc_value", pc_value, 32'h0);
        chk("rst_double_fault", 32'(double_fault), 32'(0));
        reset_l = 1'b1;
        @(negedge clock);
        chk("idle_stall", 32'(stall), 32'(0));

        for (int i = 0; i < 6; i++) begin
            run_exc(tbl[i]);
            // The eret that arrived alongside the exception must not have run.
            if (tbl[i].kind[2]) run_eret(tbl[i].exp_epc);
        end
        run_eret(32'h0000_003C);
`ifdef EXC_COUNT_EN
        chk("exc_count", 32'(exc_count), 32'(taken));
`endif

        // Reset in the middle of WAIT clears everything asynchronously.
        @(negedge clock);
        exc_opcode = 1'b1;
        pc_in      = 32'h0000_0040;
        @(negedge clock);
        exc_opcode = 1'b0;
        @(negedge clock);
        chk("pre_reset_busy", 32'(stall), 32'(1));
        #2 reset_l = 1'b0;
        #1;
        chk("arst_stall", 32'(stall), 32'(0));
        chk("arst_mem_sel", 32'(mem_sel), 32'(0));
        chk("arst_mem_addr", mem_addr, 32'h0);
        chk("arst_pc_load", 32'(pc_load), 32'(0));
        chk("arst_pc_value", pc_value, 32'h0);
        chk("arst_epc", epc, 32'h0);
        chk("arst_cause", 32'(cause), 32'(0));
        chk("arst_double_fault", 32'(double_fault), 32'(0));
`ifdef EXC_COUNT_EN
        chk("arst_exc_count", 32'(exc_count), 32'(0));
`endif
        @(negedge clock);
        reset_l = 1'b1;
        df_exp  = 1'b0;
        @(negedge clock);
        chk("post_reset_idle", 32'(stall), 32'(0));

        run_exc(tbl[0]);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
